agc_sat_monitor: RTL and testbench

- Sits directly downstream of the AGC stage and consumes its 40-bit output: 8 samples per clock, each 5-bit two's complement.
- Over a timed window it counts positive-full-scale and negative-full-scale samples and tracks peak magnitude.
- Software servoes the AGC scale and offset from these results.
- Runs entirely in the aclk domain; results are held stable for a slower-clock reader.

---
 rtl/agc_sat_monitor_if.sv | 24 ++
 rtl/agc_sat_monitor.sv | 197 +++++++++++++++++++
 tb/tb_agc_sat_monitor.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/agc_sat_monitor_if.sv
// Bus bundle between the AGC sample stream / control software and the saturation monitor.
// master drives samples and control pulses; slave returns status and window results.
interface agc_sat_monitor_if #(
  parameter int COUNT_BITS = 19
);
  logic [39:0]           dat_i;
  logic                  start_i;
  logic                  abort_i;
  logic                  busy_o;
  logic                  done_o;
  logic [COUNT_BITS-1:0] pos_sat_o;
  logic [COUNT_BITS-1:0] neg_sat_o;
  logic [4:0]            peak_o;

  modport master (
    output dat_i, start_i, abort_i,
    input  busy_o, done_o, pos_sat_o, neg_sat_o, peak_o
  );

  modport slave (
    input  dat_i, start_i, abort_i,
    output busy_o, done_o, pos_sat_o, neg_sat_o, peak_o
  );
endinterface

// File: rtl/agc_sat_monitor.sv
// Windowed full-scale counter and peak-magnitude tracker for the 8-lane, 5-bit AGC output.
// Three tagged pipeline stages (flags, per-cycle reduce, accumulate); results held between windows.
module agc_sat_monitor #(
  parameter int WINDOW_CLOCKS = 32768,
  parameter int COUNT_BITS    = 19
) (
  input logic              aclk,
  input logic              aresetn,
  agc_sat_monitor_if.slave bus
);
  localparam int NSAMP = 8;
  localparam int CW = (WINDOW_CLOCKS > 1) ? $clog2(WINDOW_CLOCKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW_CLOCKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  logic                        a_vld_q, a_vld_d;
  logic                        a_last_q, a_last_d;
  logic [NSAMP-1:0]            a_pos_q, a_pos_d;
  logic [NSAMP-1:0]            a_neg_q, a_neg_d;
  logic [NSAMP-1:0][4:0]       a_mag_q, a_mag_d;

  logic                        b_vld_q, b_vld_d;
  logic                        b_last_q, b_last_d;
  logic [3:0]                  b_pos_q, b_pos_d;
  logic [3:0]                  b_neg_q, b_neg_d;
  logic [4:0]                  b_peak_q, b_peak_d;

  logic [COUNT_BITS-1:0]       acc_pos_q, acc_pos_d;
  logic [COUNT_BITS-1:0]       acc_neg_q, acc_neg_d;
  logic [4:0]                  acc_peak_q, acc_peak_d;

  logic [COUNT_BITS-1:0]       res_pos_q, res_pos_d;
  logic [COUNT_BITS-1:0]       res_neg_q, res_neg_d;
  logic [4:0]                  res_peak_q, res_peak_d;
  logic                        done_q, done_d;

  logic [NSAMP-1:0]            lane_pos, lane_neg;
  logic [NSAMP-1:0][4:0]       lane_mag;

  // |x| of -16 is 16, which still fits the 5-bit unsigned magnitude.
  for (genvar gi = 0; gi < NSAMP; gi++) begin : g_lane
    logic [4:0] raw;
    assign raw          = bus.dat_i[5*gi +: 5];
    assign lane_pos[gi] = (raw == 5'b01111);
    assign lane_neg[gi] = (raw == 5'b10000);
    assign lane_mag[gi] = raw[4] ? (~raw + 5'd1) : raw;
  end

  logic [3:0]            pos_pop, neg_pop;
  logic [4:0]            mag_max;
  logic [COUNT_BITS:0]   pos_sum, neg_sum;
  logic [COUNT_BITS-1:0] pos_acc_nx, neg_acc_nx;
  logic [4:0]            peak_acc_nx;

  always_comb begin
    pos_pop = '0;
    neg_pop = '0;
    mag_max = '0;
    for (int i = 0; i < NSAMP; i++) begin
      pos_pop = pos_pop + {3'b000, a_pos_q[i]};
      neg_pop = neg_pop + {3'b000, a_neg_q[i]};
      if (a_mag_q[i] > mag_max) mag_max = a_mag_q[i];
    end
  end

  // Saturating accumulate: clip at all-ones rather than wrap.
  always_comb begin
    pos_sum     = {1'b0, acc_pos_q} + (COUNT_BITS+1)'(b_pos_q);
    neg_sum     = {1'b0, acc_neg_q} + (COUNT_BITS+1)'(b_neg_q);
    pos_acc_nx  = pos_sum[COUNT_BITS] ? '1 : pos_sum[COUNT_BITS-1:0];
    neg_acc_nx  = neg_sum[COUNT_BITS] ? '1 : neg_sum[COUNT_BITS-1:0];
    peak_acc_nx = (b_peak_q > acc_peak_q) ? b_peak_q : acc_peak_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_vld_d    = (state_q == RUN);
    a_last_d   = (state_q == RUN) && (cnt_q == CNT_LAST);
    a_pos_d    = lane_pos;
    a_neg_d    = lane_neg;
    a_mag_d    = lane_mag;
    b_vld_d    = a_vld_q;
    b_last_d   = a_vld_q && a_last_q;
    b_pos_d    = pos_pop;
    b_neg_d    = neg_pop;
    b_peak_d   = mag_max;
    acc_pos_d  = acc_pos_q;
    acc_neg_d  = acc_neg_q;
    acc_peak_d = acc_peak_q;
    res_pos_d  = res_pos_q;
    res_neg_d  = res_neg_q;
    res_peak_d = res_peak_q;
    done_d     = 1'b0;

    if (b_vld_q) begin
      acc_pos_d  = pos_acc_nx;
      acc_neg_d  = neg_acc_nx;
      acc_peak_d = peak_acc_nx;
      if (b_last_q) begin
        res_pos_d  = pos_acc_nx;
        res_neg_d  = neg_acc_nx;
        res_peak_d = peak_acc_nx;
        done_d     = 1'b1;
      end
    end

    case (state_q)
      RUN: begin
        if (cnt_q == CNT_LAST) state_d = DRAIN;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      DRAIN: begin
        if (b_vld_q && b_last_q) state_d = IDLE;
      end
      default: ;
    endcase

    // A start always wins: the window in flight is dropped without publishing.
    if (bus.start_i) begin
      state_d    = RUN;
      cnt_d      = '0;
      a_vld_d    = 1'b0;
      b_vld_d    = 1'b0;
      acc_pos_d  = '0;
      acc_neg_d  = '0;
      acc_peak_d = '0;
      res_pos_d  = res_pos_q;
      res_neg_d  = res_neg_q;
      res_peak_d = res_peak_q;
      done_d     = 1'b0;
    end else if (bus.abort_i && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = '0;
      a_vld_d    = 1'b0;
      b_vld_d    = 1'b0;
      res_pos_d  = res_pos_q;
      res_neg_d  = res_neg_q;
      res_peak_d = res_peak_q;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_vld_q    <= 1'b0;
      a_last_q   <= 1'b0;
      a_pos_q    <= '0;
      a_neg_q    <= '0;
      a_mag_q    <= '0;
      b_vld_q    <= 1'b0;
      b_last_q   <= 1'b0;
      b_pos_q    <= '0;
      b_neg_q    <= '0;
      b_peak_q   <= '0;
      acc_pos_q  <= '0;
      acc_neg_q  <= '0;
      acc_peak_q <= '0;
      res_pos_q  <= '0;
      res_neg_q  <= '0;
      res_peak_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_vld_q    <= a_vld_d;
      a_last_q   <= a_last_d;
      a_pos_q    <= a_pos_d;
      a_neg_q    <= a_neg_d;
      a_mag_q    <= a_mag_d;
      b_vld_q    <= b_vld_d;
      b_last_q   <= b_last_d;
      b_pos_q    <= b_pos_d;
      b_neg_q    <= b_neg_d;
      b_peak_q   <= b_peak_d;
      acc_pos_q  <= acc_pos_d;
      acc_neg_q  <= acc_neg_d;
      acc_peak_q <= acc_peak_d;
      res_pos_q  <= res_pos_d;
      res_neg_q  <= res_neg_d;
      res_peak_q <= res_peak_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = done_q;
  assign bus.pos_sat_o = res_pos_q;
  assign bus.neg_sat_o = res_neg_q;
  assign bus.peak_o    = res_peak_q;
endmodule

// File: tb/tb_agc_sat_monitor.sv
// Scoreboard bench: two monitors (wide and 4-bit counters) share one stimulus stream;
// a window-level reference model queues expected results, a negedge monitor checks them.
module tb_agc_sat_monitor;
  localparam int W    = 4;
  localparam int CB_A = 19;
  localparam int CB_B = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  agc_sat_monitor_if #(.COUNT_BITS(CB_A)) bus_a ();
  agc_sat_monitor_if #(.COUNT_BITS(CB_B)) bus_b ();

  agc_sat_monitor #(.WINDOW_CLOCKS(W), .COUNT_BITS(CB_A)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .bus(bus_a));
  agc_sat_monitor #(.WINDOW_CLOCKS(W), .COUNT_BITS(CB_B)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .bus(bus_b));

  typedef struct {
    int pos;
    int neg;
    int peak;
    int due;
  } res_t;

  res_t        exp_q[$];
  logic [39:0] m_samples[$];
  logic        m_active;
  int          m_drain;
  logic        exp_busy;
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          h_pos, h_neg, h_peak;

  logic [39:0] P15, M16, MIX, ZERO;

  function automatic int sat(input int v, input int cb);
    int lim;
    lim = (1 << cb) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  function automatic logic [39:0] rand_data();
    logic [39:0] d;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       d[5*i +: 5] = 5'b01111;
        1:       d[5*i +: 5] = 5'b10000;
        default: d[5*i +: 5] = 5'($urandom_range(0, 31));
      endcase
    end
    return d;
  endfunction

  // Window result from the raw sample words: counts of +15 / -16 and max |x|.
  function automatic res_t summarize(input int due);
    res_t r;
    logic [4:0] raw;
    int v;
    r.pos = 0; r.neg = 0; r.peak = 0; r.due = due;
    foreach (m_samples[k]) begin
      for (int i = 0; i < 8; i++) begin
        raw = m_samples[k][5*i +: 5];
        v = raw[4] ? int'(raw) - 32 : int'(raw);
        if (v == 15) r.pos++;
        if (v == -16) r.neg++;
        if (v < 0) v = -v;
        if (v > r.peak) r.peak = v;
      end
    end
    return r;
  endfunction

  task automatic cycle(input logic s, input logic a, input logic [39:0] d);
    res_t r;
    @(posedge aclk);
    #1;
    bus_a.start_i = s; bus_b.start_i = s;
    bus_a.abort_i = a; bus_b.abort_i = a;
    bus_a.dat_i   = d; bus_b.dat_i   = d;
    cyc++;
    exp_busy = m_active;
    if (s) begin
      m_active = 1'b1;
      m_samples.delete();
      m_drain = 0;
    end else if (a) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_samples.size() < W) begin
        m_samples.push_back(d);
      end else begin
        m_drain++;
        if (m_drain == 2) begin
          r = summarize(cyc + 1);
          exp_q.push_back(r);
          m_active = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, rand_data());
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".a.busy"}, int'(bus_a.busy_o), 0);
    check({tag, ".a.done"}, int'(bus_a.done_o), 0);
    check({tag, ".a.pos"},  int'(bus_a.pos_sat_o), 0);
    check({tag, ".a.neg"},  int'(bus_a.neg_sat_o), 0);
    check({tag, ".a.peak"}, int'(bus_a.peak_o), 0);
    check({tag, ".b.pos"},  int'(bus_b.pos_sat_o), 0);
    check({tag, ".b.peak"}, int'(bus_b.peak_o), 0);
  endtask

  task automatic monitor();
    res_t r;
    logic exp_done;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        h_pos = 0; h_neg = 0; h_peak = 0;
      end else begin
        exp_done = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          check("done_missed", cyc, exp_q[0].due);
          r = exp_q.pop_front();
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          r = exp_q.pop_front();
          h_pos = r.pos; h_neg = r.neg; h_peak = r.peak;
          exp_done = 1'b1;
          $display("cycle %0d: window result pos=%0d neg=%0d peak=%0d", cyc, r.pos, r.neg, r.peak);
        end
        check("a.done", int'(bus_a.done_o), int'(exp_done));
        check("a.busy", int'(bus_a.busy_o), int'(exp_busy));
        check("a.pos",  int'(bus_a.pos_sat_o), sat(h_pos, CB_A));
        check("a.neg",  int'(bus_a.neg_sat_o), sat(h_neg, CB_A));
        check("a.peak", int'(bus_a.peak_o), h_peak);
        check("b.done", int'(bus_b.done_o), int'(exp_done));
        check("b.busy", int'(bus_b.busy_o), int'(exp_busy));
        check("b.pos",  int'(bus_b.pos_sat_o), sat(h_pos, CB_B));
        check("b.neg",  int'(bus_b.neg_sat_o), sat(h_neg, CB_B));
        check("b.peak", int'(bus_b.peak_o), h_peak);
      end
    end
  endtask

  task automatic stimulus();
    // Reset state
    #3;
    check_zero_outputs("reset");
    @(posedge aclk);
    @(posedge aclk);
    #3 aresetn = 1'b1;

    // All lanes +15; the start-cycle data is also +15 and must be excluded
    cycle(1'b1, 1'b0, P15);
    repeat (5) cycle(1'b0, 1'b0, P15);
    idle(3);

    // Mixed lanes; +15 on the start cycle and on L+1 must not count
    cycle(1'b1, 1'b0, P15);
    repeat (4) cycle(1'b0, 1'b0, MIX);
    cycle(1'b0, 1'b0, P15);
    cycle(1'b0, 1'b0, P15);
    idle(3);

    // Restart at T+2 with zero data: one done, zero results
    cycle(1'b1, 1'b0, P15);
    cycle(1'b0, 1'b0, P15);
    cycle(1'b1, 1'b0, ZERO);
    repeat (6) cycle(1'b0, 1'b0, ZERO);
    idle(2);

    // Abort at T+3, then abort and start together
    cycle(1'b1, 1'b0, M16);
    repeat (2) cycle(1'b0, 1'b0, M16);
    cycle(1'b0, 1'b1, M16);
    idle(4);
    cycle(1'b1, 1'b1, M16);
    repeat (6) cycle(1'b0, 1'b0, M16);
    idle(2);

    // Abort while idle does nothing
    cycle(1'b0, 1'b1, rand_data());
    idle(2);

    // Start on the done cycle of the previous window
    cycle(1'b1, 1'b0, rand_data());
    repeat (6) cycle(1'b0, 1'b0, rand_data());
    cycle(1'b1, 1'b0, rand_data());
    repeat (6) cycle(1'b0, 1'b0, rand_data());
    idle(2);

    // Randomized starts, aborts and data
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0, rand_data());
    end
    idle(8);

    // Asynchronous reset mid-RUN, then a fresh window
    cycle(1'b1, 1'b0, P15);
    repeat (6) cycle(1'b0, 1'b0, P15);
    cycle(1'b1, 1'b0, P15);
    cycle(1'b0, 1'b0, P15);
    cycle(1'b0, 1'b0, P15);
    #2 aresetn = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    m_active = 1'b0;
    exp_busy = 1'b0;
    exp_q.delete();
    bus_a.start_i = 1'b0; bus_b.start_i = 1'b0;
    bus_a.abort_i = 1'b0; bus_b.abort_i = 1'b0;
    @(posedge aclk);
    #3 aresetn = 1'b1;
    cycle(1'b1, 1'b0, ZERO);
    repeat (4) cycle(1'b0, 1'b0, MIX);
    idle(6);

    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    P15  = {8{5'b01111}};
    M16  = {8{5'b10000}};
    MIX  = {5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'b01111, 5'b10000, 5'b10000};
    ZERO = '0;
    bus_a.dat_i = '0; bus_b.dat_i = '0;
    bus_a.start_i = 1'b0; bus_b.start_i = 1'b0;
    bus_a.abort_i = 1'b0; bus_b.abort_i = 1'b0;
    m_active = 1'b0; m_drain = 0; exp_busy = 1'b0;
    cyc = 0; n_checks = 0; n_pass = 0;
    h_pos = 0; h_neg = 0; h_peak = 0;
    fork
      stimulus();
      monitor();
      begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
